// File: rtl/cpu_core_pkg.sv
// Shared types for the parametrised processing core: opcodes, FSM states
// and the highest legal opcode value.
package cpu_core_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_MUL   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_LOAD  = 4'd8,
    OP_STORE = 4'd9,
    OP_PASSA = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPND,
    S_EXEC,
    S_MEM,
    S_DONE
  } state_e;

  localparam logic [3:0] OP_LAST_VALID = 4'd10;

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational 2*WIDTH ALU. The multiplier exists only when CPU_CORE_MUL_EN
// is defined; otherwise MUL is reported as an invalid opcode.
module cpu_core_alu
  import cpu_core_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  op_e                op,
  output logic [2*WIDTH-1:0] value,
  output logic               op_invalid
);

  localparam int SH_W = $clog2(2 * WIDTH);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    value      = '0;
    op_invalid = (op > OP_LAST_VALID);
    case (op)
      OP_ADD:   value = a + b;
      OP_SUB:   value = a - b;
      OP_AND:   value = a & b;
      OP_OR:    value = a | b;
      OP_XOR:   value = a ^ b;
      OP_MUL: begin
`ifdef CPU_CORE_MUL_EN
        value = a * b;
`else
        op_invalid = 1'b1;
`endif
      end
      OP_SHL:   value = a << b[SH_W-1:0];
      OP_SHR:   value = a >> b[SH_W-1:0];
      OP_PASSA: value = a;
      default:  value = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised command-driven core: channel mux, operand registers, ALU,
// result register and data memory. Optional multiplier: CPU_CORE_MUL_EN.
module cpu_core_param
  import cpu_core_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 4,
  parameter int MEM_DEPTH = 16,
  parameter int SEL_W     = $clog2(NUM_IN),
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cpu_rdy,
  input  logic [3:0]              cmd_op,
  input  logic [SEL_W-1:0]        cmd_sel_a,
  input  logic [SEL_W-1:0]        cmd_sel_b,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [NUM_IN*WIDTH-1:0] din,
  output logic [2*WIDTH-1:0]      result,
  output logic                    result_valid,
  output logic                    zero,
  output logic                    error
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  state_e               state;
  op_e                  op_q;
  logic [SEL_W-1:0]     sel_a_q, sel_b_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [2*WIDTH-1:0]   opa, opb, rd_data, alu_value;
  logic                 alu_invalid;
  logic [2*WIDTH-1:0]   mem [MEM_DEPTH];

  // Out-of-range selects fall back to channel 0 rather than flagging an error.
  function automatic logic [WIDTH-1:0] chan(input logic [NUM_IN*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] sel);
    int idx;
    idx = (int'(sel) < NUM_IN) ? int'(sel) : 0;
    return bus[idx*WIDTH +: WIDTH];
  endfunction

  logic is_load, is_store, addr_bad, exec_error;
  assign is_load    = (op_q == OP_LOAD);
  assign is_store   = (op_q == OP_STORE);
  assign addr_bad   = ({1'b0, addr_q} >= DEPTH_L);
  assign exec_error = alu_invalid || ((is_load || is_store) && addr_bad);

  cpu_core_alu #(.WIDTH(WIDTH)) u_alu (
    .a          (opa),
    .b          (opb),
    .op         (op_q),
    .value      (alu_value),
    .op_invalid (alu_invalid)
  );

  assign cpu_rdy      = (state == S_IDLE);
  assign result_valid = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      sel_a_q <= '0;
      sel_b_q <= '0;
      addr_q  <= '0;
      opa     <= '0;
      opb     <= '0;
      rd_data <= '0;
      result  <= '0;
      zero    <= 1'b1;
      error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q    <= op_e'(cmd_op);
          sel_a_q <= cmd_sel_a;
          sel_b_q <= cmd_sel_b;
          addr_q  <= cmd_addr;
          state   <= S_OPND;
        end
        S_OPND: begin
          opa   <= {{WIDTH{1'b0}}, chan(din, sel_a_q)};
          opb   <= {{WIDTH{1'b0}}, chan(din, sel_b_q)};
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_error) begin
            error <= 1'b1;
            zero  <= (result == '0);
            state <= S_DONE;
          end else if (is_load) begin
            rd_data <= mem[addr_q];
            state   <= S_MEM;
          end else begin
            error <= 1'b0;
            if (is_store) begin
              zero <= (result == '0);
            end else begin
              result <= alu_value;
              zero   <= (alu_value == '0);
            end
            state <= S_DONE;
          end
        end
        S_MEM: begin
          result <= rd_data;
          zero   <= (rd_data == '0);
          error  <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (state == S_EXEC && is_store && !exec_error) mem[addr_q] <= result;
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param (WIDTH=8, NUM_IN=4, MEM_DEPTH=12): directed table,
// reset/hold sequences and random commands against a behavioural model.
module tb_cpu_core_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cpu_rdy;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_sel_a, cmd_sel_b;
  logic [3:0]  cmd_addr;
  logic [31:0] din;
  logic [15:0] result;
  logic        result_valid, zero, error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model_result;
  logic [15:0] model_mem [12];

  always #5 clk = ~clk;

  cpu_core_param #(.WIDTH(8), .NUM_IN(4), .MEM_DEPTH(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cpu_rdy      (cpu_rdy),
    .cmd_op       (cmd_op),
    .cmd_sel_a    (cmd_sel_a),
    .cmd_sel_b    (cmd_sel_b),
    .cmd_addr     (cmd_addr),
    .din          (din),
    .result       (result),
    .result_valid (result_valid),
    .zero         (zero),
    .error        (error)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sa, sb;
    logic [3:0]  addr;
    logic [31:0] d;
    logic [15:0] er;
    bit          ez, ee;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the selected channels.
  task automatic predict(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [3:0] addr, input logic [31:0] d,
                         output logic [15:0] r, output bit z, output bit e);
    int a, b;
    a = int'(d[sa*8 +: 8]);
    b = int'(d[sb*8 +: 8]);
    r = model_result;
    e = 1'b0;
    case (op)
      4'd0: r = 16'(a + b);
      4'd1: r = 16'(a - b);
      4'd2: r = 16'(a & b);
      4'd3: r = 16'(a | b);
      4'd4: r = 16'(a ^ b);
      4'd5: begin
`ifdef CPU_CORE_MUL_EN
        r = 16'(a * b);
`else
        e = 1'b1;
`endif
      end
      4'd6: r = 16'(a << (b % 16));
      4'd7: r = 16'(a >> (b % 16));
      4'd8: if (addr >= 4'd12) e = 1'b1; else r = model_mem[addr];
      4'd9: if (addr >= 4'd12) e = 1'b1;
      4'd10: r = 16'(a);
      default: e = 1'b1;
    endcase
    z = (r == 16'd0);
  endtask

  // Issue one command, check latency, outputs and strobe width, update the model.
  task automatic apply(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [3:0] addr, input logic [31:0] d,
                       input logic [15:0] er, input bit ez, input bit ee, input bit hold);
    int edges, exp_edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    exp_edges = (op == 4'd8 && addr < 4'd12 && !ee) ? 3 : 2;
    @(negedge clk);
    check("rdy_before_cmd", cpu_rdy, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel_a = sa;
    cmd_sel_b = sb;
    cmd_addr  = addr;
    din       = ~d;
    @(posedge clk);
    @(negedge clk);
    din = d;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_op    = 4'($urandom);
      cmd_sel_a = 2'($urandom);
      cmd_sel_b = 2'($urandom);
      cmd_addr  = 4'($urandom);
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      din = $urandom;
      if (result_valid) begin
        edges = i;
        seen  = 1'b1;
        break;
      end
    end
    if (!seen) check("result_valid_timeout", 0, 1);
    check("latency", edges, exp_edges);
    check("result", result, er);
    check("zero", zero, ez);
    check("error", error, ee);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("strobe_one_cycle_rdy", {result_valid, cpu_rdy}, 2'b01);
    model_result = er;
    if (op == 4'd9 && !ee) model_mem[addr] = er;
  endtask

  vec_t vecs [20];
  int   rv_count;

  initial begin
    logic [15:0] r;
    bit z, e;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_sel_a = '0;
    cmd_sel_b = '0;
    cmd_addr  = '0;
    din       = '0;
    model_result = '0;

    vecs[0]  = '{4'd0,  2'd2, 2'd3, 4'd0,  32'hFFFF_0000, 16'h01FE, 1'b0, 1'b0};
    vecs[1]  = '{4'd1,  2'd0, 2'd1, 4'd0,  32'h0000_0201, 16'hFFFF, 1'b0, 1'b0};
`ifdef CPU_CORE_MUL_EN
    vecs[2]  = '{4'd5,  2'd0, 2'd1, 4'd0,  32'h0000_FFFF, 16'hFE01, 1'b0, 1'b0};
`else
    vecs[2]  = '{4'd5,  2'd0, 2'd1, 4'd0,  32'h0000_FFFF, 16'hFFFF, 1'b0, 1'b1};
`endif
    vecs[3]  = '{4'd0,  2'd0, 2'd1, 4'd0,  32'h0000_0201, 16'h0003, 1'b0, 1'b0};
    vecs[4]  = '{4'd9,  2'd0, 2'd0, 4'd5,  32'h1234_5678, 16'h0003, 1'b0, 1'b0};
    vecs[5]  = '{4'd1,  2'd0, 2'd1, 4'd0,  32'h0000_0707, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{4'd8,  2'd0, 2'd0, 4'd5,  32'h0000_0000, 16'h0003, 1'b0, 1'b0};
    vecs[7]  = '{4'd8,  2'd0, 2'd0, 4'd13, 32'h0000_0000, 16'h0003, 1'b0, 1'b1};
    vecs[8]  = '{4'd15, 2'd0, 2'd1, 4'd0,  32'h0000_0101, 16'h0003, 1'b0, 1'b1};
    vecs[9]  = '{4'd0,  2'd1, 2'd1, 4'd0,  32'hFFFF_00FF, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{4'd12, 2'd0, 2'd0, 4'd0,  32'h0000_0000, 16'h0000, 1'b1, 1'b1};
    vecs[11] = '{4'd6,  2'd0, 2'd1, 4'd0,  32'h0000_0F81, 16'h8000, 1'b0, 1'b0};
    vecs[12] = '{4'd7,  2'd0, 2'd1, 4'd0,  32'h0000_1380, 16'h0010, 1'b0, 1'b0};
    vecs[13] = '{4'd9,  2'd0, 2'd0, 4'd11, 32'h0000_0000, 16'h0010, 1'b0, 1'b0};
    vecs[14] = '{4'd2,  2'd2, 2'd3, 4'd0,  32'h3CF0_0000, 16'h0030, 1'b0, 1'b0};
    vecs[15] = '{4'd3,  2'd2, 2'd3, 4'd0,  32'h3CF0_0000, 16'h00FC, 1'b0, 1'b0};
    vecs[16] = '{4'd4,  2'd2, 2'd3, 4'd0,  32'h3CF0_0000, 16'h00CC, 1'b0, 1'b0};
    vecs[17] = '{4'd10, 2'd3, 2'd0, 4'd0,  32'hA500_0000, 16'h00A5, 1'b0, 1'b0};
    vecs[18] = '{4'd8,  2'd0, 2'd0, 4'd11, 32'h0000_0000, 16'h0010, 1'b0, 1'b0};
    vecs[19] = '{4'd8,  2'd0, 2'd0, 4'd12, 32'h0000_0000, 16'h0010, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values, then idle with no strobe.
    check("reset_result", result, 16'h0000);
    check("reset_zero", zero, 1);
    check("reset_error", error, 0);
    check("reset_rdy", cpu_rdy, 1);
    rv_count = 0;
    repeat (6) begin
      @(negedge clk);
      if (result_valid) rv_count++;
    end
    check("idle_no_strobe", rv_count, 0);

    foreach (vecs[i])
      apply(vecs[i].op, vecs[i].sa, vecs[i].sb, vecs[i].addr, vecs[i].d,
            vecs[i].er, vecs[i].ez, vecs[i].ee, 1'b0);

    // STORE at an out-of-range address leaves result and memory alone.
    apply(4'd9, 2'd0, 2'd0, 4'd12, 32'h0, 16'h0010, 1'b0, 1'b1, 1'b0);

    // cmd_valid held through the whole command: exactly one execution.
    apply(4'd0, 2'd0, 2'd1, 4'd0, 32'h0000_0403, 16'h0007, 1'b0, 1'b0, 1'b1);
    rv_count = 0;
    repeat (8) begin
      @(negedge clk);
      if (result_valid || !cpu_rdy) rv_count++;
    end
    check("hold_single_exec", rv_count, 0);
    check("hold_result_kept", result, 16'h0007);

    // Reset during S_OPND of a STORE to address 5: the write must not happen.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'd9;
    cmd_addr  = 4'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("abort_rdy", cpu_rdy, 1);
    check("abort_result", result, 16'h0000);
    check("abort_zero", zero, 1);
    check("abort_valid", result_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    model_result = 16'h0000;
    @(negedge clk);
    check("rdy_after_reset", cpu_rdy, 1);
    apply(4'd8, 2'd0, 2'd0, 4'd5, 32'h0, 16'h0003, 1'b0, 1'b0, 1'b0);

    // Fill every memory word with a known random value.
    for (int a = 0; a < 12; a++) begin
      logic [31:0] d;
      d = $urandom;
      predict(4'd10, 2'd0, 2'd0, 4'd0, d, r, z, e);
      apply(4'd10, 2'd0, 2'd0, 4'd0, d, r, z, e, 1'b0);
      predict(4'd9, 2'd0, 2'd0, 4'(a), d, r, z, e);
      apply(4'd9, 2'd0, 2'd0, 4'(a), d, r, z, e, 1'b0);
    end

    // Random commands against the model.
    for (int k = 0; k < 60; k++) begin
      logic [3:0]  op, addr;
      logic [1:0]  sa, sb;
      logic [31:0] d;
      op   = 4'($urandom_range(0, 15));
      sa   = 2'($urandom);
      sb   = 2'($urandom);
      addr = 4'($urandom_range(0, 15));
      d    = $urandom;
      predict(op, sa, sb, addr, d, r, z, e);
      apply(op, sa, sb, addr, d, r, z, e, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
